// File: rtl/add8_err_meter_if.sv
// Operand/result link between the error meter and a combinational add8_* adder.
interface add8_err_meter_if #(
   parameter int unsigned W = 8
);
   logic [W-1:0] dut_a;
   logic [W-1:0] dut_b;
   logic [W:0]   dut_o;

   modport master (output dut_a, output dut_b, input dut_o);
   modport slave  (input dut_a, input dut_b, output dut_o);
endinterface

// File: rtl/add8_err_meter.sv
// Exhaustive sweep of an approximate adder: counts errors, sums |error|,
// tracks worst-case error and captures the first failing operand pair.
module add8_err_meter #(
   parameter int unsigned W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   add8_err_meter_if.master  dut,
   output logic              busy,
   output logic              done,
   output logic [2*W:0]      err_cnt,
   output logic [2*W+8:0]    err_sum,
   output logic [W:0]        wce,
   output logic              ff_valid,
   output logic [W-1:0]      ff_a,
   output logic [W-1:0]      ff_b
);
   localparam int unsigned IW = 2 * W;
   localparam int unsigned CW = 2 * W + 1;
   localparam int unsigned SW = 2 * W + 9;
   localparam int unsigned OW = W + 1;
   localparam int unsigned DW = W + 2;
   localparam logic [IW-1:0] IDX_LAST = '1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state_q;
   state_t          state_d;
   logic            launch;
   logic [IW-1:0]   idx;

   logic            cap_valid;
   logic [W-1:0]    cap_a;
   logic [W-1:0]    cap_b;
   logic [OW-1:0]   cap_o;

   logic [OW-1:0]        exact;
   logic signed [DW-1:0] diff;
   logic [DW-1:0]        mag;
   logic [OW-1:0]        err;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; abort overrides every other transition
   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               launch  = !abort;
            end
         end
         RUN:     if (idx == IDX_LAST) state_d = DRAIN;
         DRAIN:   state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   assign dut.dut_a = idx[W-1:0];
   assign dut.dut_b = idx[IW-1:W];

   // Error magnitude of the captured vector, 10-bit signed difference
   always_comb begin
      exact = OW'(cap_a) + OW'(cap_b);
      diff  = $signed({1'b0, cap_o}) - $signed({1'b0, exact});
      mag   = diff[DW-1] ? DW'(-diff) : DW'(diff);
      err   = OW'(mag);
   end

   // Index, capture stage, accumulate stage and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cap_valid <= 1'b0;
         cap_a     <= '0;
         cap_b     <= '0;
         cap_o     <= '0;
         err_cnt   <= '0;
         err_sum   <= '0;
         wce       <= '0;
         ff_valid  <= 1'b0;
         ff_a      <= '0;
         ff_b      <= '0;
      end else begin
         busy      <= (state_d == RUN) || (state_d == DRAIN);
         done      <= (state_q == DRAIN) && !abort;
         cap_valid <= (state_q == RUN) && !abort;
         if (state_q == RUN) begin
            cap_a <= idx[W-1:0];
            cap_b <= idx[IW-1:W];
            cap_o <= dut.dut_o;
         end

         if (abort || launch || state_q == DRAIN) idx <= '0;
         else if (state_q == RUN && idx != IDX_LAST) idx <= idx + IW'(1);

         if (abort || launch) begin
            err_cnt  <= '0;
            err_sum  <= '0;
            wce      <= '0;
            ff_valid <= 1'b0;
            ff_a     <= '0;
            ff_b     <= '0;
         end else if (cap_valid && err != '0) begin
            err_cnt <= err_cnt + CW'(1);
            err_sum <= err_sum + SW'(err);
            if (err > wce) wce <= err;
            if (!ff_valid) begin
               ff_valid <= 1'b1;
               ff_a     <= cap_a;
               ff_b     <= cap_b;
            end
         end
      end
   end
endmodule

// File: tb/tb_add8_err_meter.sv
// Randomised check of add8_err_meter against a vector-by-vector software model,
// using a 4-bit instance for control scenarios and one full 8-bit sweep.
module tb_add8_err_meter;
   localparam int unsigned SW = 4;
   localparam int unsigned BW = 8;
   localparam int SN = 1 << (2 * SW);
   localparam int BN = 1 << (2 * BW);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic s_start, s_abort, b_start, b_abort;

   logic              s_busy, s_done, s_ff_valid;
   logic [2*SW:0]     s_err_cnt;
   logic [2*SW+8:0]   s_err_sum;
   logic [SW:0]       s_wce;
   logic [SW-1:0]     s_ff_a, s_ff_b;

   logic              b_busy, b_done, b_ff_valid;
   logic [2*BW:0]     b_err_cnt;
   logic [2*BW+8:0]   b_err_sum;
   logic [BW:0]       b_wce;
   logic [BW-1:0]     b_ff_a, b_ff_b;

   int n_checks = 0;
   int n_fail   = 0;
   int s_mode   = 0;
   int s_delta [SN];
   int b_delta [BN];

   add8_err_meter_if #(.W(SW)) s_if ();
   add8_err_meter_if #(.W(BW)) b_if ();

   add8_err_meter #(.W(SW)) u_small (
      .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .dut(s_if),
      .busy(s_busy), .done(s_done), .err_cnt(s_err_cnt), .err_sum(s_err_sum),
      .wce(s_wce), .ff_valid(s_ff_valid), .ff_a(s_ff_a), .ff_b(s_ff_b)
   );

   add8_err_meter #(.W(BW)) u_big (
      .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .dut(b_if),
      .busy(b_busy), .done(b_done), .err_cnt(b_err_cnt), .err_sum(b_err_sum),
      .wce(b_wce), .ff_valid(b_ff_valid), .ff_a(b_ff_a), .ff_b(b_ff_b)
   );

   // Behavioural 4-bit adders under test, selected by mode
   function automatic int s_adder(input int mode, input int a, input int b, input int d);
      case (mode)
         0:       return a + b;
         1:       return 0;
         2:       return a + b + 1;
         3:       return a + b + d;
         default: return (((a >> 2) + (b >> 2)) << 2) | ((a | b) & 3);
      endcase
   endfunction

   int s_ai, s_bi, b_ai, b_bi;
   always_comb begin
      s_ai = int'(s_if.dut_a);
      s_bi = int'(s_if.dut_b);
      s_if.dut_o = 5'(s_adder(s_mode, s_ai, s_bi, s_delta[s_bi * 16 + s_ai]));
   end

   always_comb begin
      b_ai = int'(b_if.dut_a);
      b_bi = int'(b_if.dut_b);
      b_if.dut_o = 9'(b_ai + b_bi + b_delta[b_bi * 256 + b_ai]);
   end

   logic [2*SW-1:0] s_idx;
   assign s_idx = {s_if.dut_b, s_if.dut_a};

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference figures of merit over the whole sweep in index order
   task automatic model(input int w, input int mode, output longint cnt, output longint sum,
                        output longint wmax, output longint ffv, output longint ffa,
                        output longint ffb);
      int n, a, b, o, e;
      n = 1 << (2 * w);
      cnt = 0; sum = 0; wmax = 0; ffv = 0; ffa = 0; ffb = 0;
      for (int k = 0; k < n; k++) begin
         a = k % (1 << w);
         b = k / (1 << w);
         if (w == SW) o = s_adder(mode, a, b, s_delta[k]);
         else         o = a + b + b_delta[k];
         e = (o > a + b) ? o - (a + b) : (a + b) - o;
         if (e != 0) begin
            cnt++;
            sum += e;
            if (ffv == 0) begin ffv = 1; ffa = a; ffb = b; end
         end
         if (e > wmax) wmax = e;
      end
   endtask

   task automatic check_small_reset(input string tag);
      check({tag, " busy"},     longint'(s_busy), 0);
      check({tag, " done"},     longint'(s_done), 0);
      check({tag, " err_cnt"},  longint'(s_err_cnt), 0);
      check({tag, " err_sum"},  longint'(s_err_sum), 0);
      check({tag, " wce"},      longint'(s_wce), 0);
      check({tag, " ff_valid"}, longint'(s_ff_valid), 0);
      check({tag, " ff_a"},     longint'(s_ff_a), 0);
      check({tag, " ff_b"},     longint'(s_ff_b), 0);
      check({tag, " operands"}, longint'(s_idx), 0);
   endtask

   task automatic fill_small_table(input int pct);
      int m, ex;
      for (int k = 0; k < SN; k++) begin
         s_delta[k] = 0;
         if ($urandom_range(99, 0) < pct) begin
            m  = $urandom_range(15, 1);
            ex = (k % 16) + (k / 16);
            if ($urandom_range(1, 0) == 1) m = -m;
            if (ex + m < 0 || ex + m > 31) m = -m;
            s_delta[k] = m;
         end
      end
   endtask

   // One full small sweep; optional extra start pulse when index hits restart_at
   task automatic s_run(input string tag, input int mode, input int restart_at);
      int cycles, busy_low;
      longint cnt, sum, wmax, ffv, ffa, ffb;
      s_mode = mode;
      @(negedge clk) s_start = 1'b1;
      @(posedge clk);
      cycles = 1;
      busy_low = 0;
      @(negedge clk) s_start = 1'b0;
      while (!s_done && cycles < 1000) begin
         if (!s_busy) busy_low++;
         s_start = (restart_at >= 0 && int'(s_idx) == restart_at);
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
      s_start = 1'b0;
      check({tag, " done latency"}, cycles, SN + 2);
      check({tag, " busy gaps"}, busy_low, 0);
      check({tag, " busy at done"}, longint'(s_busy), 0);
      check({tag, " operands at done"}, longint'(s_idx), 0);
      model(SW, mode, cnt, sum, wmax, ffv, ffa, ffb);
      check({tag, " err_cnt"},  longint'(s_err_cnt), cnt);
      check({tag, " err_sum"},  longint'(s_err_sum), sum);
      check({tag, " wce"},      longint'(s_wce), wmax);
      check({tag, " ff_valid"}, longint'(s_ff_valid), ffv);
      check({tag, " ff_a"},     longint'(s_ff_a), ffa);
      check({tag, " ff_b"},     longint'(s_ff_b), ffb);
      @(negedge clk);
      check({tag, " done width"}, longint'(s_done), 0);
      check({tag, " held err_cnt"}, longint'(s_err_cnt), cnt);
   endtask

   initial begin
      int t, y, dones, busys, m, ex, cycles;
      longint cnt, sum, wmax, ffv, ffa, ffb;
      rst = 1'b1;
      s_start = 1'b0; s_abort = 1'b0;
      b_start = 1'b0; b_abort = 1'b0;
      for (int k = 0; k < BN; k++) begin
         m  = $urandom_range(40, 1);
         ex = (k % 256) + (k / 256);
         if ($urandom_range(1, 0) == 1) m = -m;
         if (ex + m < 0 || ex + m > 511) m = -m;
         b_delta[k] = m;
      end
      fill_small_table(25);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      check_small_reset("reset");
      check("reset big busy", longint'(b_busy), 0);
      check("reset big err_cnt", longint'(b_err_cnt), 0);

      s_run("exact", 0, -1);
      s_run("zero", 1, -1);
      s_run("plus1", 2, -1);
      s_run("table", 3, -1);
      s_run("loa", 4, -1);

      // Extra start mid-sweep is ignored
      s_run("restart", 3, int'($urandom_range(200, 10)));

      // Abort while running, then a fresh sweep
      y = int'($urandom_range(240, 20));
      s_mode = 1;
      @(negedge clk) s_start = 1'b1;
      @(posedge clk);
      @(negedge clk) s_start = 1'b0;
      t = 0;
      while (int'(s_idx) != y && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check("abort reach index", longint'(s_idx), longint'(y));
      s_abort = 1'b1;
      @(posedge clk);
      @(negedge clk) s_abort = 1'b0;
      check_small_reset("abort");
      dones = 0; busys = 0;
      repeat (10) begin
         @(negedge clk);
         if (s_done) dones++;
         if (s_busy) busys++;
      end
      check("abort no done", dones, 0);
      check("abort stays idle", busys, 0);
      fill_small_table(60);
      s_run("after abort", 3, -1);

      // Abort from DONE clears held results
      s_run("pre done abort", 1, -1);
      @(negedge clk) s_abort = 1'b1;
      @(negedge clk) s_abort = 1'b0;
      check("done abort err_sum", longint'(s_err_sum), 0);
      check("done abort ff_valid", longint'(s_ff_valid), 0);

      // Reset mid-sweep, then start together with abort
      s_mode = 2;
      @(negedge clk) s_start = 1'b1;
      @(negedge clk) s_start = 1'b0;
      repeat (int'($urandom_range(120, 30))) @(negedge clk);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      check_small_reset("mid rst");
      s_start = 1'b1; s_abort = 1'b1;
      @(negedge clk);
      s_start = 1'b0; s_abort = 1'b0;
      check_small_reset("start+abort");
      busys = 0;
      repeat (5) begin
         @(negedge clk);
         if (s_busy) busys++;
      end
      check("start+abort stays idle", busys, 0);

      // Full 8-bit sweep where every vector is wrong
      @(negedge clk) b_start = 1'b1;
      @(posedge clk);
      cycles = 1;
      @(negedge clk) b_start = 1'b0;
      while (!b_done && cycles < 70000) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
      check("big done latency", cycles, BN + 2);
      model(BW, 0, cnt, sum, wmax, ffv, ffa, ffb);
      check("big err_cnt", longint'(b_err_cnt), cnt);
      check("big err_cnt full", longint'(b_err_cnt), BN);
      check("big err_sum", longint'(b_err_sum), sum);
      check("big wce", longint'(b_wce), wmax);
      check("big ff_valid", longint'(b_ff_valid), ffv);
      check("big ff_a", longint'(b_ff_a), ffa);
      check("big ff_b", longint'(b_ff_b), ffb);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
